// File: rtl/peripheral_spram_pkg.sv
// peripheral_spram_pkg: shared state type and word-geometry helpers for the scratchpad RAM core
package peripheral_spram_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_BYTES_PER_WORD = DEF_DATA_WIDTH / 8;
  localparam int unsigned DEF_OFS = $clog2(DEF_BYTES_PER_WORD);
  function automatic int unsigned bytes_per_word(input int unsigned dw);
    return dw / 8;
  endfunction
  function automatic int unsigned ofs(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/peripheral_spram_if.sv
// peripheral_spram_if: request/response bus between the AXI4 adapter and the RAM core
interface peripheral_spram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
);
  logic                    req_i;
  logic                    we_i;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic [DATA_WIDTH-1:0]   data_i;
  logic [DATA_WIDTH-1:0]   data_o;
  logic                    rvalid_o;
  logic                    ready_o;
  logic                    err_o;
  modport master (output req_i, we_i, addr_i, be_i, data_i, input data_o, rvalid_o, ready_o, err_o);
  modport slave (input req_i, we_i, addr_i, be_i, data_i, output data_o, rvalid_o, ready_o, err_o);
endinterface

// File: rtl/peripheral_spram_ram.sv
// peripheral_spram_ram: single-port word array with byte-lane writes and a registered read port
module peripheral_spram_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 1024,
  localparam int IW = $clog2(DEPTH),
  localparam int BPW = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic                  clr,
  input  logic [IW-1:0]         idx,
  input  logic [BPW-1:0]        be,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // the array itself has no reset; only the read register does
  always_ff @(posedge clk) begin
    for (int k = 0; k < BPW; k++)
      if (we && be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/peripheral_spram_core.sv
// peripheral_spram_core: clear-on-reset FSM, address decode and response flags around the RAM
module peripheral_spram_core
  import peripheral_spram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input logic HCLK,
  input logic HRESET,
  peripheral_spram_if.slave bus
);
  localparam int OFS = ofs(DATA_WIDTH);
  localparam int IW = $clog2(DEPTH);
  localparam int BPW = bytes_per_word(DATA_WIDTH);
  state_t state, next_state;
  logic [IW-1:0] cnt, aidx;
  logic ready_q, rvalid_q, err_q, acc, oor, init;
  assign init = state == INIT;
  assign acc = bus.req_i & ready_q;
  assign aidx = bus.addr_i[OFS +: IW];
  assign oor = |(bus.addr_i >> (OFS + IW));
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= INIT_ON_RESET ? INIT : RUN;
    else state <= next_state;
  end
  always_comb begin
    next_state = state;
    next_state = (init && cnt == IW'(DEPTH - 1)) ? RUN : state;
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt      <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt      <= init ? cnt + 1'b1 : cnt;
      ready_q  <= next_state == RUN;
      rvalid_q <= acc & ~bus.we_i;
      err_q    <= acc & oor;
    end
  end
  // during INIT the clear counter owns the single RAM port; no requests are accepted then
  peripheral_spram_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (HCLK),
    .rst   (HRESET),
    .we    (init | (acc & bus.we_i & ~oor)),
    .re    (acc & ~bus.we_i & ~oor),
    .clr   (acc & ~bus.we_i & oor),
    .idx   (init ? cnt : aidx),
    .be    (init ? {BPW{1'b1}} : bus.be_i),
    .wdata (init ? '0 : bus.data_i),
    .rdata (bus.data_o)
  );
  assign bus.ready_o  = ready_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.err_o    = err_q;
endmodule
